// File: rtl/sum_accumulator.sv
// Running-total consumer for the 8-bit adder stage: accumulates {carry,sum} results
// under valid/ready, counts samples, and streams a snapshot of the total LSB first.
module sum_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_sum,
    input  logic             in_carry,
    input  logic             clear,
    input  logic             rd_req,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             acc_overflow,
    output logic [CNT_W-1:0] sample_count
);
    localparam int NB    = ACC_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {ACCUM = 1'b0, READ = 1'b1} state_t;

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   snap_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               out_valid_reg;
    logic [7:0]         out_byte_reg;
    logic               out_last_reg;
    logic               overflow_reg;
    logic [CNT_W-1:0]   count_reg;

    logic [7:0]         snap_bytes [NB];
    logic               accept;
    logic [ACC_W+1:0]   sum_wide;
    logic [ACC_W-1:0]   acc_next;
    logic               wrap;
    logic               last_idx;
    logic [IDX_W-1:0]   idx_next;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bytes
            assign snap_bytes[gi] = snap_reg[8*gi +: 8];
        end
    endgenerate

    assign in_ready = (state_reg == ACCUM) && !clear;
    assign accept   = in_valid && in_ready;

    // Two guard bits: with ACC_W=8 the 9-bit addend alone can exceed the total width.
    assign sum_wide = {2'b00, acc_reg} + (ACC_W+2)'({in_carry, in_sum});
    assign wrap     = accept && (sum_wide[ACC_W+1:ACC_W] != 2'b00);
    assign acc_next = accept ? sum_wide[ACC_W-1:0] : acc_reg;
    assign last_idx = (idx_reg == IDX_W'(NB - 1));
    assign idx_next = idx_reg + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            snap_reg      <= '0;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_byte_reg  <= 8'h00;
            out_last_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            count_reg     <= '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (clear) begin
                        acc_reg      <= '0;
                        count_reg    <= '0;
                        overflow_reg <= 1'b0;
                    end else begin
                        acc_reg <= acc_next;
                        if (accept && (count_reg != '1))
                            count_reg <= count_reg + CNT_W'(1);
                        if (wrap)
                            overflow_reg <= 1'b1;
                        // The first byte is launched on the request edge so it appears next cycle.
                        if (rd_req) begin
                            snap_reg      <= acc_next;
                            out_valid_reg <= 1'b1;
                            out_byte_reg  <= acc_next[7:0];
                            out_last_reg  <= (NB == 1);
                            idx_reg       <= '0;
                            state_reg     <= READ;
                        end
                    end
                end
                READ: begin
                    if (last_idx) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        state_reg     <= ACCUM;
                    end else begin
                        idx_reg       <= idx_next;
                        out_byte_reg  <= snap_bytes[idx_next];
                        out_last_reg  <= (idx_next == IDX_W'(NB - 1));
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_byte     = out_byte_reg;
    assign out_last     = out_last_reg;
    assign acc_overflow = overflow_reg;
    assign sample_count = count_reg;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator (ACC_W=16): vector table plus hand-written
// sequences for wrap, saturation, readout blocking and reset during readout.
module tb_sum_accumulator;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_carry, clear, rd_req;
    logic [7:0] in_sum;
    logic       out_valid, out_last, acc_overflow;
    logic [7:0] out_byte;
    logic [7:0] sample_count;

    int checks = 0;
    int errors = 0;

    sum_accumulator #(.ACC_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .clear(clear), .rd_req(rd_req),
        .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
        .acc_overflow(acc_overflow), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] sum;
        logic       c;
        logic       clr;
        logic       rd;
        logic       e_ready;
        logic [7:0] e_cnt;
        logic       e_ovf;
        logic       e_ov;
        logic [7:0] e_byte;
        logic       e_last;
    } vec_t;

    function automatic vec_t mk(logic v, logic [7:0] sum, logic c, logic clr, logic rd,
                                logic e_ready, logic [7:0] e_cnt, logic e_ovf,
                                logic e_ov, logic [7:0] e_byte, logic e_last);
        vec_t r;
        r.v = v; r.sum = sum; r.c = c; r.clr = clr; r.rd = rd;
        r.e_ready = e_ready; r.e_cnt = e_cnt; r.e_ovf = e_ovf;
        r.e_ov = e_ov; r.e_byte = e_byte; r.e_last = e_last;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_sum = 8'h00; in_carry = 1'b0; clear = 1'b0; rd_req = 1'b0;
    endtask

    // Pulses rd_req and checks the two readout bytes plus the return to idle.
    task automatic expect_read(input string name, input logic [15:0] total);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk({name, " b0 valid"}, 32'(out_valid), 32'd1);
        chk({name, " b0 byte"}, 32'(out_byte), 32'(total[7:0]));
        chk({name, " b0 last"}, 32'(out_last), 32'd0);
        tick();
        chk({name, " b1 valid"}, 32'(out_valid), 32'd1);
        chk({name, " b1 byte"}, 32'(out_byte), 32'(total[15:8]));
        chk({name, " b1 last"}, 32'(out_last), 32'd1);
        tick();
        chk({name, " done valid"}, 32'(out_valid), 32'd0);
        chk({name, " done ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[14];
    int   lows, ovs;

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_byte", 32'(out_byte), 32'h00);
        chk("reset out_last", 32'(out_last), 32'd0);
        chk("reset overflow", 32'(acc_overflow), 32'd0);
        chk("reset count", 32'(sample_count), 32'd0);
        rst = 1'b0;

        //              v  sum    c  clr rd  rdy cnt  ovf ov byte   last
        vecs[0]  = mk(1, 8'h02, 0, 0, 0, 1, 8'd1, 0, 0, 8'h00, 0);
        vecs[1]  = mk(1, 8'h10, 0, 0, 0, 1, 8'd2, 0, 0, 8'h00, 0);
        vecs[2]  = mk(1, 8'h00, 1, 0, 0, 1, 8'd3, 0, 0, 8'h00, 0);
        vecs[3]  = mk(1, 8'hFF, 0, 0, 0, 1, 8'd4, 0, 0, 8'h00, 0);
        vecs[4]  = mk(0, 8'h00, 0, 0, 1, 1, 8'd4, 0, 1, 8'h11, 0);
        vecs[5]  = mk(0, 8'h00, 0, 0, 0, 0, 8'd4, 0, 1, 8'h02, 1);
        vecs[6]  = mk(0, 8'h00, 0, 0, 0, 0, 8'd4, 0, 0, 8'h02, 0);
        vecs[7]  = mk(1, 8'h05, 0, 1, 0, 0, 8'd0, 0, 0, 8'h02, 0);
        vecs[8]  = mk(1, 8'h03, 0, 0, 0, 1, 8'd1, 0, 0, 8'h02, 0);
        vecs[9]  = mk(1, 8'h05, 0, 0, 1, 1, 8'd2, 0, 1, 8'h08, 0);
        vecs[10] = mk(0, 8'h00, 0, 0, 0, 0, 8'd2, 0, 1, 8'h00, 1);
        vecs[11] = mk(0, 8'h00, 0, 0, 0, 0, 8'd2, 0, 0, 8'h00, 0);
        vecs[12] = mk(0, 8'h00, 0, 1, 1, 0, 8'd0, 0, 0, 8'h00, 0);
        vecs[13] = mk(0, 8'h00, 0, 0, 0, 1, 8'd0, 0, 0, 8'h00, 0);

        for (int i = 0; i < 14; i++) begin
            in_valid = vecs[i].v; in_sum = vecs[i].sum; in_carry = vecs[i].c;
            clear = vecs[i].clr; rd_req = vecs[i].rd;
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
            tick();
            chk($sformatf("vec%0d count", i), 32'(sample_count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d overflow", i), 32'(acc_overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d out_byte", i), 32'(out_byte), 32'(vecs[i].e_byte));
            chk($sformatf("vec%0d out_last", i), 32'(out_last), 32'(vecs[i].e_last));
        end
        idle();

        // Wrap: 128 x 511 stays below 2^16, the 129th sample wraps to 0x017F.
        in_valid = 1'b1; in_sum = 8'hFF; in_carry = 1'b1;
        for (int i = 0; i < 128; i++) tick();
        chk("wrap pre overflow", 32'(acc_overflow), 32'd0);
        chk("wrap pre count", 32'(sample_count), 32'd128);
        tick();
        idle();
        chk("wrap overflow", 32'(acc_overflow), 32'd1);
        chk("wrap count", 32'(sample_count), 32'd129);
        expect_read("wrap total", 16'h017F);
        chk("overflow sticky", 32'(acc_overflow), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear count", 32'(sample_count), 32'd0);
        chk("clear overflow", 32'(acc_overflow), 32'd0);
        expect_read("clear total", 16'h0000);

        // Counter saturation: 256 zero-valued samples leave the count at 255.
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) tick();
        idle();
        chk("saturated count", 32'(sample_count), 32'd255);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Readout blocking with in_valid held and rd_req repeated during READ.
        lows = 0; ovs = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sum = 8'h01; in_carry = 1'b0;
            rd_req = (i < 3);
            #1;
            if (!in_ready) lows++;
            tick();
            if (out_valid) ovs++;
        end
        idle();
        chk("block ready low cycles", 32'(lows), 32'd2);
        chk("block out_valid cycles", 32'(ovs), 32'd2);
        chk("block count", 32'(sample_count), 32'd4);
        expect_read("block total", 16'h0004);

        // Reset while the first readout byte is on the output.
        in_valid = 1'b1; in_sum = 8'h33;
        tick();
        idle();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("mid rd first byte", 32'(out_byte), 32'h37);
        chk("mid rd first valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst out_byte", 32'(out_byte), 32'h00);
        chk("mid rst out_last", 32'(out_last), 32'd0);
        chk("mid rst count", 32'(sample_count), 32'd0);
        chk("mid rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();
        chk("post rst out_valid", 32'(out_valid), 32'd0);
        expect_read("post rst total", 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 8-bit adder stage: accepts each adder result (8-bit sum plus carry-out) through a valid/ready handshake and adds it into a running ACC_W-bit total. It counts accepted samples, flags wrap-around of the total, and on request streams a snapshot of the total out byte-serially, least significant byte first. It sits between the adder output and the project's narrow output port.

## Interface
- ACC_W, 16, accumulator width; multiple of 8, legal range 8..32
- CNT_W, 8, sample counter width
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  adder result present this cycle
- in_ready  output  1  block accepts a result this cycle
- in_sum  input  8  adder sum
- in_carry  input  1  adder carry-out
- clear  input  1  zero the accumulator, counter and overflow flag
- rd_req  input  1  request a byte-serial readout of the total
- out_valid  output  1  out_byte holds a readout byte
- out_byte  output  8  readout byte
- out_last  output  1  marks the final (most significant) readout byte
- acc_overflow  output  1  sticky flag: total has wrapped since the last clear/reset
- sample_count  output  CNT_W  number of accepted samples, saturating

## Operation
- States: ACCUM, READ. A byte index runs from 0 to ACC_W/8-1 while in READ.
- in_ready = (state==ACCUM) && !clear. This is combinational and is the only combinational output.
- Sample acceptance: a sample is accepted when in_valid && in_ready. acc <= acc + {in_carry,in_sum}, with the 9-bit addend (0..511) zero-extended. The sum wraps modulo 2^ACC_W.
- Overflow: acc_overflow is set when the carry out of bit ACC_W-1 is 1. It stays set until clear or rst.
- Sample counter: sample_count increments on each accepted sample and saturates at 2^CNT_W-1.
- clear (ACCUM only):
  - acc, sample_count and acc_overflow go to 0 on the next edge.
  - clear wins over a simultaneous in_valid; that sample is not accepted.
  - clear wins over a simultaneous rd_req; no readout starts.
  - clear is ignored in READ.
- rd_req in ACCUM (without clear):
  - A snapshot register loads the post-update total, so a sample accepted in the same cycle is included.
  - State goes to READ with byte index 0.
- READ:
  - Each cycle drives out_byte = snapshot[8*idx +: 8] with out_valid=1.
  - out_last=1 when idx = ACC_W/8-1; on that cycle the state returns to ACCUM.
  - There is no backpressure on the output.
  - rd_req and in_valid are ignored; in_ready=0, so upstream holds its data.
- Outside READ: out_valid=0 and out_last=0; out_byte holds its last value.
- rst mid-readout: aborts immediately. The state returns to ACCUM and all outputs take their reset values.

## Timing
- Reset values:
  - state=ACCUM; acc=0, snapshot=0
  - out_valid=0, out_byte=0x00, out_last=0
  - acc_overflow=0, sample_count=0
  - in_ready=1 (when clear=0)
- Accept latency: a sample accepted at edge N is visible in acc and sample_count after edge N; up to one sample per cycle.
- Readout latency:
  - rd_req sampled at edge N: first byte has out_valid=1 in cycle N+1.
  - The last byte is in cycle N+ACC_W/8.
  - in_ready returns high in cycle N+ACC_W/8+1.
- acc_overflow rises in the cycle after the wrapping sample's edge.
- All outputs except in_ready are registered.

## Test plan
- Reset: assert rst for 2 cycles → all outputs at their reset values, in_ready=1.
- Adder sequence (ACC_W=16): accept (sum,carry) = (0x02,0), (0x10,0), (0x00,1), (0xFF,0); then pulse rd_req.
  - Expected: sample_count=4.
  - Readout: out_byte 0x11 (out_last=0), then 0x02 (out_last=1).
  - acc_overflow=0.
- Wrap: accept (0xFF,1) 129 times, i.e. 511×129 = 65919.
  - Expected: acc=0x017F, acc_overflow=1, sample_count=129.
  - A following clear zeroes acc, sample_count and acc_overflow.
- Simultaneous events:
  - clear with in_valid (0x05,0): sample not accepted, acc=0.
  - rd_req with in_valid (0x05,0) on acc=0x0003: snapshot reads 0x08, 0x00.
- Readout blocking: hold in_valid=1 during READ → in_ready=0 for exactly 2 cycles, no samples lost or double-counted, and a second rd_req is ignored.
- rst mid-readout: assert rst in the cycle the first byte is out → next cycle out_valid=0, acc=0, state back to ACCUM.
